// File: rtl/shift_register_sequencer.sv
// Load/shift/done sequencer driving an external universal shift register.
// Optional feature: define SHIFT_PAUSE_EN to add a pause input that stalls SHIFT.
module shift_register_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_in,
    output logic [1:0]       ctrl,
    output logic [WIDTH-1:0] d,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic [WIDTH-1:0] dout
`ifdef SHIFT_PAUSE_EN
    ,
    input  logic             pause
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] CTRL_HOLD  = 2'b00;
    localparam logic [1:0] CTRL_LEFT  = 2'b01;
    localparam logic [1:0] CTRL_RIGHT = 2'b10;
    localparam logic [1:0] CTRL_LOAD  = 2'b11;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;

    logic             w_stall;
    logic [CNT_W-1:0] w_shamt_clamped;

`ifdef SHIFT_PAUSE_EN
    assign w_stall = pause;
`else
    assign w_stall = 1'b0;
`endif

    assign w_shamt_clamped = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;

    // abort outranks every state transition, including a start seen in IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_dir   <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_data  <= din;
                        r_dir   <= dir;
                        r_cnt   <= w_shamt_clamped;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= (r_cnt != '0) ? S_SHIFT : S_DONE;
                end
                S_SHIFT: begin
                    if (!w_stall) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state; reset forces the idle/cleared view immediately
    always_comb begin
        ctrl       = CTRL_HOLD;
        d          = r_data;
        ready      = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        dout       = '0;
        if (reset) begin
            d     = '0;
            ready = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready = 1'b1;
                end
                S_LOAD: begin
                    ctrl = CTRL_LOAD;
                end
                S_SHIFT: begin
                    sout = r_dir ? q_in[0] : q_in[WIDTH-1];
                    if (!w_stall) begin
                        ctrl       = r_dir ? CTRL_RIGHT : CTRL_LEFT;
                        sout_valid = 1'b1;
                    end
                end
                default: begin
                    done = 1'b1;
                    dout = q_in;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Randomized scoreboard bench for shift_register_sequencer with a behavioural shift register.
module tb_shift_register_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    typedef struct {
        logic [WIDTH-1:0] dout;
        int               cyc;
    } done_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] din;
    logic             abort;
    logic             pause;
    logic [WIDTH-1:0] q_in = '0;
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;
    logic [WIDTH-1:0] dout;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    sq[$];
    done_t dq[$];

    shift_register_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dir        (dir),
        .shamt      (shamt),
        .din        (din),
        .abort      (abort),
        .q_in       (q_in),
        .ctrl       (ctrl),
        .d          (d),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done),
        .dout       (dout)
`ifdef SHIFT_PAUSE_EN
        ,
        .pause      (pause)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External universal shift register: zero fill on shifts
    always @(posedge clk) begin
        case (ctrl)
            2'b11:   q_in <= d;
            2'b01:   q_in <= q_in << 1;
            2'b10:   q_in <= q_in >> 1;
            default: q_in <= q_in;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected stream bits and completions as the DUT presents them
    initial begin
        bit    b;
        done_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sout_valid === 1'b1) begin
                if (sq.size() == 0) begin
                    chk("sout_unexpected", 32'(sout_valid), 32'(0));
                end else begin
                    b = sq.pop_front();
                    chk("sout_bit", 32'(sout), 32'(b));
                end
            end
            if (done === 1'b1) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'(0));
                end else begin
                    e = dq.pop_front();
                    chk("done_dout", 32'(dout), 32'(e.dout));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("wait_ready", 32'(ready), 32'(1));
    endtask

    task automatic run_op(input logic [WIDTH-1:0] wd, input logic wdir, input logic [CNT_W-1:0] wsh,
                          input bit hold, input int abort_at, input int reset_at, input int pause_at);
        int    k, extra, c0, s, pcnt, pa;
        bit    cur_p, pdone;
        done_t e;
        k     = (int'(wsh) > WIDTH) ? WIDTH : int'(wsh);
        extra = 0;
        pa    = -1;
`ifdef SHIFT_PAUSE_EN
        pa = pause_at;
        if (pa >= 1 && pa < k) extra = 2;
`else
        if (pause_at > 0) pa = -1;
`endif
        wait_ready();
        c0 = cyc;
        for (int i = 0; i < k; i++) sq.push_back(wdir ? wd[i] : wd[WIDTH-1-i]);
        e.dout = wdir ? (wd >> k) : (wd << k);
        e.cyc  = c0 + k + 2 + extra;
        dq.push_back(e);
        start = 1'b1;
        din   = wd;
        dir   = wdir;
        shamt = wsh;
        @(negedge clk);
        if (!hold) start = 1'b0;
        din   = WIDTH'($urandom);
        dir   = 1'($urandom);
        shamt = CNT_W'($urandom);
        chk("load_ctrl", 32'(ctrl), 32'(3));
        chk("load_d", 32'(d), 32'(wd));
        chk("load_ready", 32'(ready), 32'(0));
        s = 0; cur_p = 1'b0; pcnt = 0; pdone = 1'b0;
        while (s < k) begin
            @(negedge clk);
            if (cur_p) begin
                chk("pause_ctrl", 32'(ctrl), 32'(0));
                chk("pause_sout_valid", 32'(sout_valid), 32'(0));
            end else begin
                chk("shift_ctrl", 32'(ctrl), wdir ? 32'(2) : 32'(1));
                chk("shift_sout_valid", 32'(sout_valid), 32'(1));
                s++;
            end
            if (s == abort_at || s == reset_at) begin
                if (s == abort_at) abort = 1'b1;
                else reset = 1'b1;
                start = 1'b0;
                pause = 1'b0;
                sq.delete();
                dq.delete();
                @(negedge clk);
                chk("cancel_ready", 32'(ready), 32'(1));
                chk("cancel_done", 32'(done), 32'(0));
                chk("cancel_ctrl", 32'(ctrl), 32'(0));
                chk("cancel_sout_valid", 32'(sout_valid), 32'(0));
                if (reset === 1'b1) begin
                    chk("rst_d", 32'(d), 32'(0));
                    chk("rst_dout", 32'(dout), 32'(0));
                    chk("rst_sout", 32'(sout), 32'(0));
                end
                abort = 1'b0;
                reset = 1'b0;
                return;
            end
            if (s == pa && !pdone) begin
                pcnt  = 2;
                pdone = 1'b1;
            end
            cur_p = (pcnt > 0);
            pause = cur_p;
            if (pcnt > 0) pcnt--;
        end
        pause = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'(1));
        chk("done_ctrl", 32'(ctrl), 32'(0));
        start = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'(1));
        chk("idle_done", 32'(done), 32'(0));
    endtask

    initial begin
        logic [WIDTH-1:0] rd;
        logic             rdir;
        logic [CNT_W-1:0] rsh;
        int               rk, ab;
        reset = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        dir = 1'b0; shamt = '0; din = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctrl", 32'(ctrl), 32'(0));
        chk("reset_d", 32'(d), 32'(0));
        chk("reset_ready", 32'(ready), 32'(1));
        chk("reset_sout", 32'(sout), 32'(0));
        chk("reset_sout_valid", 32'(sout_valid), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_dout", 32'(dout), 32'(0));
        reset = 1'b0;

        run_op(8'hB4, 1'b0, 4'd3, 1'b0, -1, -1, -1);
        run_op(8'hB4, 1'b1, 4'd2, 1'b0, -1, -1, -1);
        run_op(8'hFF, 1'b0, 4'd0, 1'b0, -1, -1, -1);
        run_op(8'hFF, 1'b0, 4'd12, 1'b0, -1, -1, -1);
        run_op(8'hFF, 1'b1, 4'd8, 1'b1, -1, -1, -1);
        run_op(8'h5A, 1'b0, 4'd5, 1'b1, 2, -1, -1);

        // abort together with start in IDLE drops the request
        wait_ready();
        start = 1'b1; abort = 1'b1; din = 8'h77; shamt = 4'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_ready", 32'(ready), 32'(1));
        chk("abort_start_ctrl", 32'(ctrl), 32'(0));
        @(negedge clk);
        chk("abort_start_idle", 32'(ready), 32'(1));

        run_op(8'hC3, 1'b1, 4'd6, 1'b0, -1, 3, -1);
        run_op(8'h96, 1'b0, 4'd4, 1'b0, -1, -1, -1);
`ifdef SHIFT_PAUSE_EN
        run_op(8'h96, 1'b0, 4'd4, 1'b0, -1, -1, 2);
`endif

        for (int n = 0; n < 40; n++) begin
            rd   = WIDTH'($urandom);
            rdir = 1'($urandom);
            rsh  = CNT_W'($urandom);
            rk   = (int'(rsh) > WIDTH) ? WIDTH : int'(rsh);
            ab   = ($urandom_range(0, 4) == 0 && rk >= 1) ? int'($urandom_range(1, rk)) : -1;
            run_op(rd, rdir, rsh, 1'($urandom), ab, -1, int'($urandom_range(1, 3)));
        end

        repeat (3) @(negedge clk);
        chk("sout_queue_empty", sq.size(), 32'(0));
        chk("done_queue_empty", dq.size(), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
